// File: rtl/cmdout_in_arbiter_pkg.sv
// Shared types and constants for the command-out input arbiter and its
// round-robin helper.
package cmdout_in_arbiter_pkg;

    // Arbiter state: wait for a requester, or stream the granted packet.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } cmdout_arb_state_t;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

endpackage

// File: rtl/cmdout_in_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: the first requester found when scanning
// upward from last_grant+1, wrapping at N. Reusable by other arbiters.
module rr_priority_pick #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last_grant,
    output logic [W-1:0] o_winner,
    output logic         o_any
);

    int w_idx;

    // Scan N slots starting after the last winner; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(i_last_grant) + k) % N;
            if (!o_any && i_req[W'(w_idx)]) begin
                o_winner = W'(w_idx);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmdout_in_arbiter.sv
// Packet-atomic round-robin arbiter merging per-accelerator finish-command
// streams into one TID-tagged stream. A granted accelerator owns the output
// until its TLAST beat is accepted; a one-entry output slice registers beats.
module cmdout_in_arbiter
    import cmdout_in_arbiter_pkg::*;
#(
    parameter int MAX_ACCS = 16,
    parameter int ACC_BITS = $clog2(MAX_ACCS),
    parameter int DBG_REGS = 0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [MAX_ACCS-1:0][63:0]     acc_TDATA,
    input  logic [MAX_ACCS-1:0]           acc_TVALID,
    input  logic [MAX_ACCS-1:0]           acc_TLAST,
    output logic [MAX_ACCS-1:0]           acc_TREADY,
    output logic [63:0]                   outStream_TDATA,
    output logic                          outStream_TVALID,
    output logic [ACC_BITS-1:0]           outStream_TID,
    output logic                          outStream_TLAST,
    input  logic                          outStream_TREADY,
    output logic [MAX_ACCS-1:0][31:0]     num_pkts
);

    cmdout_arb_state_t     r_state;
    logic [ACC_BITS-1:0]   r_grant;
    logic [ACC_BITS-1:0]   r_last_grant;
    logic [DATA_W-1:0]     r_data;
    logic [ACC_BITS-1:0]   r_tid;
    logic                  r_last;
    logic                  r_valid;

    logic [ACC_BITS-1:0]   w_winner;
    logic                  w_any;
    logic                  w_slot_free;
    logic                  w_accept;
    logic                  w_pkt_done;

    rr_priority_pick #(
        .N (MAX_ACCS),
        .W (ACC_BITS)
    ) u_pick (
        .i_req        (acc_TVALID),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    // The slice can take a new beat when empty or being drained this cycle.
    assign w_slot_free = !r_valid || outStream_TREADY;
    assign w_accept    = (r_state == XFER) && acc_TVALID[r_grant] && w_slot_free;
    assign w_pkt_done  = w_accept && acc_TLAST[r_grant];

    // Ready is offered only to the granted accelerator, only while streaming.
    always_comb begin
        acc_TREADY = '0;
        if (r_state == XFER) begin
            acc_TREADY[r_grant] = w_slot_free;
        end
    end

    // Arbitration FSM plus the registered output slice.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= ACC_BITS'(MAX_ACCS - 1);
            r_data       <= '0;
            r_tid        <= '0;
            r_last       <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_winner;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_pkt_done) begin
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_accept) begin
                r_data  <= acc_TDATA[r_grant];
                r_tid   <= r_grant;
                r_last  <= acc_TLAST[r_grant];
                r_valid <= 1'b1;
            end else if (outStream_TREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign outStream_TDATA  = r_data;
    assign outStream_TID    = r_tid;
    assign outStream_TLAST  = r_last;
    assign outStream_TVALID = r_valid;

    generate
        if (DBG_REGS != 0) begin : g_dbg
            logic [MAX_ACCS-1:0][CNT_W-1:0] r_num_pkts;

            // Count completed packets per source accelerator.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_num_pkts <= '0;
                end else if (w_pkt_done) begin
                    r_num_pkts[r_grant] <= r_num_pkts[r_grant] + 32'd1;
                end
            end

            assign num_pkts = r_num_pkts;
        end else begin : g_no_dbg
            assign num_pkts = '0;
        end
    endgenerate

endmodule

// File: tb/tb_cmdout_in_arbiter.sv
// Directed self-checking bench for cmdout_in_arbiter: reset, single packet,
// round-robin contention, wrap-around, backpressure, late requester and
// reset in the middle of a packet.
module tb_cmdout_in_arbiter;

    localparam int N  = 16;
    localparam int AB = 4;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [N-1:0][63:0]   acc_TDATA;
    logic [N-1:0]         acc_TVALID;
    logic [N-1:0]         acc_TLAST;
    logic [N-1:0]         acc_TREADY;
    logic [63:0]          outStream_TDATA;
    logic                 outStream_TVALID;
    logic [AB-1:0]        outStream_TID;
    logic                 outStream_TLAST;
    logic                 outStream_TREADY;
    logic [N-1:0][31:0]   num_pkts;

    cmdout_in_arbiter #(
        .MAX_ACCS (N),
        .ACC_BITS (AB),
        .DBG_REGS (1)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .acc_TDATA        (acc_TDATA),
        .acc_TVALID       (acc_TVALID),
        .acc_TLAST        (acc_TLAST),
        .acc_TREADY       (acc_TREADY),
        .outStream_TDATA  (outStream_TDATA),
        .outStream_TVALID (outStream_TVALID),
        .outStream_TID    (outStream_TID),
        .outStream_TLAST  (outStream_TLAST),
        .outStream_TREADY (outStream_TREADY),
        .num_pkts         (num_pkts)
    );

    always #5 clk = ~clk;

    // Per-accelerator beat sources: {last, data}.
    logic [64:0] src_mem [N][32];
    int          src_wr  [N];
    int          src_rd  [N];

    // Beats observed leaving the arbiter.
    logic [63:0] ob_data [64];
    logic [AB-1:0] ob_tid [64];
    logic        ob_last [64];
    int          ob_cyc  [64];
    int          ob_n;

    logic        prev_valid, prev_ready, prev_last;
    logic [63:0] prev_data;
    logic [AB-1:0] prev_tid;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    function automatic logic [63:0] pkt_word(input int acc, input int pkt, input int b);
        logic [7:0] a8, p8, b8;
        a8 = acc[7:0];
        p8 = pkt[7:0];
        b8 = 8'(b + 1);
        return {32'hA5A5_0000, 8'h00, a8, p8, b8};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                acc_TVALID[i] = 1'b1;
                acc_TDATA[i]  = src_mem[i][src_rd[i]][63:0];
                acc_TLAST[i]  = src_mem[i][src_rd[i]][64];
            end else begin
                acc_TVALID[i] = 1'b0;
                acc_TDATA[i]  = 64'd0;
                acc_TLAST[i]  = 1'b0;
            end
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        drive_inputs();
    endtask

    task automatic load_pkt(input int acc, input int pkt, input int len);
        for (int b = 0; b < len; b++) begin
            src_mem[acc][src_wr[acc]] = {(b == len - 1), pkt_word(acc, pkt, b)};
            src_wr[acc]++;
        end
        drive_inputs();
    endtask

    // One clock: sample at negedge, advance sources after the posedge.
    task automatic step();
        logic [N-1:0] fire;
        #1;
        fire = acc_TVALID & acc_TREADY;
        total_cnt++;
        if ($countones(acc_TREADY) > 1) $display("FAIL ready_onehot: acc_TREADY=%h, at most one bit allowed", acc_TREADY);
        else pass_cnt++;
        if (outStream_TVALID && !outStream_TREADY) begin
            total_cnt++;
            if (acc_TREADY !== '0) $display("FAIL ready_stall: acc_TREADY=%h while slice stalled, required 0", acc_TREADY);
            else pass_cnt++;
        end
        if (prev_valid && !prev_ready) begin
            total_cnt++;
            if (outStream_TVALID !== 1'b1 || outStream_TDATA !== prev_data ||
                outStream_TID !== prev_tid || outStream_TLAST !== prev_last)
                $display("FAIL hold: v=%b d=%h id=%0d l=%b, required v=1 d=%h id=%0d l=%b",
                         outStream_TVALID, outStream_TDATA, outStream_TID, outStream_TLAST,
                         prev_data, prev_tid, prev_last);
            else pass_cnt++;
        end
        if (outStream_TVALID && outStream_TREADY && ob_n < 64) begin
            ob_data[ob_n] = outStream_TDATA;
            ob_tid[ob_n]  = outStream_TID;
            ob_last[ob_n] = outStream_TLAST;
            ob_cyc[ob_n]  = cyc;
            ob_n++;
        end
        prev_valid = outStream_TVALID;
        prev_ready = outStream_TREADY;
        prev_data  = outStream_TDATA;
        prev_tid   = outStream_TID;
        prev_last  = outStream_TLAST;
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (fire[i]) src_rd[i]++;
        drive_inputs();
        @(negedge clk);
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (ob_n < n && k < budget) begin
            step();
            k++;
        end
        total_cnt++;
        if (ob_n < n) $display("FAIL timeout: beats=%0d, required %0d", ob_n, n);
        else pass_cnt++;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        outStream_TREADY = 1'b1;
        clear_src();
        repeat (3) step();
        rstn = 1'b1;
        ob_n = 0;
        prev_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt += 6;
        if (acc_TREADY !== '0) $display("FAIL rst_tready: %h, required 0", acc_TREADY); else pass_cnt++;
        if (outStream_TVALID !== 1'b0) $display("FAIL rst_tvalid: %b, required 0", outStream_TVALID); else pass_cnt++;
        if (outStream_TDATA !== 64'd0) $display("FAIL rst_tdata: %h, required 0", outStream_TDATA); else pass_cnt++;
        if (outStream_TID !== 4'd0) $display("FAIL rst_tid: %0d, required 0", outStream_TID); else pass_cnt++;
        if (outStream_TLAST !== 1'b0) $display("FAIL rst_tlast: %b, required 0", outStream_TLAST); else pass_cnt++;
        if (num_pkts !== '0) $display("FAIL rst_num_pkts: %h, required 0", num_pkts); else pass_cnt++;
    endtask

    task automatic test_single();
        int c0;
        clear_src();
        ob_n = 0;
        c0 = cyc;
        load_pkt(5, 0, 3);
        #1;
        total_cnt++;
        if (acc_TREADY !== 16'h0000) $display("FAIL single_idle_ready: %h, required 0000", acc_TREADY); else pass_cnt++;
        step();
        #1;
        total_cnt++;
        if (acc_TREADY !== 16'h0020) $display("FAIL single_grant_ready: %h, required 0020", acc_TREADY); else pass_cnt++;
        run_until(3, 20);
        for (int b = 0; b < 3; b++) begin
            total_cnt += 3;
            if (ob_tid[b] !== 4'd5) $display("FAIL single_tid%0d: %0d, required 5", b, ob_tid[b]); else pass_cnt++;
            if (ob_data[b] !== pkt_word(5, 0, b)) $display("FAIL single_data%0d: %h, required %h", b, ob_data[b], pkt_word(5, 0, b)); else pass_cnt++;
            if (ob_last[b] !== (b == 2)) $display("FAIL single_last%0d: %b, required %b", b, ob_last[b], (b == 2)); else pass_cnt++;
        end
        total_cnt += 2;
        if (ob_cyc[0] - c0 != 2) $display("FAIL single_latency: %0d cycles, required 2", ob_cyc[0] - c0); else pass_cnt++;
        if (ob_cyc[2] - ob_cyc[0] != 2) $display("FAIL single_throughput: %0d cycles for 3 beats, required 2", ob_cyc[2] - ob_cyc[0]); else pass_cnt++;
        repeat (2) step();
        total_cnt++;
        if (num_pkts[5] !== 32'd1) $display("FAIL single_num_pkts: %0d, required 1", num_pkts[5]); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int exp_acc [5] = '{0, 3, 15, 0, 3};
        int exp_pkt [5] = '{0, 0, 0, 1, 1};
        int idx;
        do_reset();
        load_pkt(0, 0, 3);
        load_pkt(0, 1, 3);
        load_pkt(3, 0, 3);
        load_pkt(3, 1, 3);
        load_pkt(15, 0, 3);
        run_until(15, 100);
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 3; b++) begin
                idx = p * 3 + b;
                total_cnt += 3;
                if (ob_tid[idx] !== 4'(exp_acc[p])) $display("FAIL rr_tid%0d: %0d, required %0d", idx, ob_tid[idx], exp_acc[p]); else pass_cnt++;
                if (ob_data[idx] !== pkt_word(exp_acc[p], exp_pkt[p], b)) $display("FAIL rr_data%0d: %h, required %h", idx, ob_data[idx], pkt_word(exp_acc[p], exp_pkt[p], b)); else pass_cnt++;
                if (ob_last[idx] !== (b == 2)) $display("FAIL rr_last%0d: %b, required %b", idx, ob_last[idx], (b == 2)); else pass_cnt++;
            end
            if (p > 0) begin
                total_cnt++;
                if (ob_cyc[p * 3] - ob_cyc[(p - 1) * 3] != 4) $display("FAIL rr_spacing%0d: %0d cycles, required 4", p, ob_cyc[p * 3] - ob_cyc[(p - 1) * 3]); else pass_cnt++;
            end
        end
        repeat (2) step();
        total_cnt += 3;
        if (num_pkts[0] !== 32'd2) $display("FAIL rr_num_pkts0: %0d, required 2", num_pkts[0]); else pass_cnt++;
        if (num_pkts[3] !== 32'd2) $display("FAIL rr_num_pkts3: %0d, required 2", num_pkts[3]); else pass_cnt++;
        if (num_pkts[15] !== 32'd1) $display("FAIL rr_num_pkts15: %0d, required 1", num_pkts[15]); else pass_cnt++;
    endtask

    task automatic test_wrap();
        clear_src();
        ob_n = 0;
        load_pkt(15, 0, 3);
        run_until(3, 20);
        repeat (2) step();
        ob_n = 0;
        load_pkt(15, 1, 3);
        load_pkt(2, 0, 3);
        run_until(6, 40);
        total_cnt += 3;
        if (ob_tid[0] !== 4'd2) $display("FAIL wrap_first: %0d, required 2", ob_tid[0]); else pass_cnt++;
        if (ob_tid[3] !== 4'd15) $display("FAIL wrap_second: %0d, required 15", ob_tid[3]); else pass_cnt++;
        if (ob_data[3] !== pkt_word(15, 1, 0)) $display("FAIL wrap_data: %h, required %h", ob_data[3], pkt_word(15, 1, 0)); else pass_cnt++;
        repeat (2) step();
    endtask

    task automatic test_backpressure();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int k;
        clear_src();
        ob_n = 0;
        outStream_TREADY = 1'b1;
        load_pkt(6, 0, 3);
        k = 0;
        #1;
        while (!outStream_TVALID && k < 10) begin
            step();
            #1;
            k++;
        end
        for (int i = 0; i < 4; i++) begin
            outStream_TREADY = pat[i];
            #1;
            if (i == 1 || i == 2) begin
                total_cnt += 3;
                if (acc_TREADY !== 16'h0000) $display("FAIL bp_ready_low%0d: %h, required 0000", i, acc_TREADY); else pass_cnt++;
                if (outStream_TDATA !== pkt_word(6, 0, 1)) $display("FAIL bp_data%0d: %h, required %h", i, outStream_TDATA, pkt_word(6, 0, 1)); else pass_cnt++;
                if (outStream_TID !== 4'd6) $display("FAIL bp_tid%0d: %0d, required 6", i, outStream_TID); else pass_cnt++;
            end else begin
                total_cnt++;
                if (acc_TREADY !== 16'h0040) $display("FAIL bp_ready_high%0d: %h, required 0040", i, acc_TREADY); else pass_cnt++;
            end
            step();
        end
        outStream_TREADY = 1'b1;
        run_until(3, 20);
        repeat (3) step();
        total_cnt++;
        if (ob_n != 3) $display("FAIL bp_count: %0d beats, required 3", ob_n); else pass_cnt++;
        for (int b = 0; b < 3; b++) begin
            total_cnt++;
            if (ob_data[b] !== pkt_word(6, 0, b)) $display("FAIL bp_beat%0d: %h, required %h", b, ob_data[b], pkt_word(6, 0, b)); else pass_cnt++;
        end
    endtask

    task automatic test_late();
        int k;
        clear_src();
        ob_n = 0;
        load_pkt(7, 0, 3);
        k = 0;
        while (ob_n < 1 && k < 10) begin
            step();
            k++;
        end
        load_pkt(1, 0, 3);
        run_until(6, 40);
        for (int b = 0; b < 6; b++) begin
            total_cnt++;
            if (ob_tid[b] !== ((b < 3) ? 4'd7 : 4'd1)) $display("FAIL late_tid%0d: %0d, required %0d", b, ob_tid[b], (b < 3) ? 7 : 1); else pass_cnt++;
        end
        total_cnt += 2;
        if (ob_cyc[3] - ob_cyc[2] != 2) $display("FAIL late_gap: %0d cycles, required 2", ob_cyc[3] - ob_cyc[2]); else pass_cnt++;
        if (ob_data[3] !== pkt_word(1, 0, 0)) $display("FAIL late_data: %h, required %h", ob_data[3], pkt_word(1, 0, 0)); else pass_cnt++;
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        int k;
        clear_src();
        ob_n = 0;
        load_pkt(4, 0, 3);
        k = 0;
        #1;
        while (!outStream_TVALID && k < 10) begin
            step();
            #1;
            k++;
        end
        rstn = 1'b0;
        step();
        #1;
        total_cnt += 2;
        if (outStream_TVALID !== 1'b0) $display("FAIL midrst_tvalid: %b, required 0", outStream_TVALID); else pass_cnt++;
        if (acc_TREADY !== 16'h0000) $display("FAIL midrst_tready: %h, required 0000", acc_TREADY); else pass_cnt++;
        clear_src();
        step();
        rstn = 1'b1;
        ob_n = 0;
        prev_valid = 1'b0;
        load_pkt(15, 0, 3);
        load_pkt(0, 0, 3);
        run_until(6, 40);
        total_cnt += 2;
        if (ob_tid[0] !== 4'd0) $display("FAIL midrst_first: %0d, required 0", ob_tid[0]); else pass_cnt++;
        if (ob_tid[3] !== 4'd15) $display("FAIL midrst_second: %0d, required 15", ob_tid[3]); else pass_cnt++;
    endtask

    initial begin
        rstn = 1'b0;
        outStream_TREADY = 1'b1;
        ob_n = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_last = 1'b0;
        prev_data = 64'd0;
        prev_tid = '0;
        clear_src();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_late();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
